load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_BYTES, default 4096, byte capacity of the downstream data memory; legal addresses are 0..MEM_BYTES-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  unit accepts request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_ctrl  input  3  access type: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core consumes response.
REQ-012 resp_rdata  output  32  load data (extended by memory); 0 for stores and errors.
REQ-013 resp_err  output  1  request rejected (misaligned, out of range, illegal ctrl).
REQ-014 DMAddress  output  32  address to data memory.
REQ-015 DMDataIn  output  32  write data to data memory.
REQ-016 DMCtrl  output  3  access type to data memory.
REQ-017 DMWrEnable  output  1  write strobe to data memory.
REQ-018 DMDataOut  input  32  read data from data memory (memory updates it on falling edge).
REQ-019 err_count  output  8  saturating count of error responses.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP; reset state IDLE.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
REQ-022 On acceptance, req_addr/req_ctrl/req_wdata/req_we SHALL be registered; later changes on req_* are ignored until the next acceptance.
REQ-023 Error check at acceptance: ctrl in {011,110,111}; store with ctrl 100/101; half access with addr[0]=1; word access with addr[1:0]!=00; addr + size - 1 > MEM_BYTES-1 (computed without 32-bit wrap).
REQ-024 Erroneous request: IDLE -> RESP directly; no DM access; resp_err=1, resp_rdata=0.
REQ-025 Legal request: IDLE -> ACCESS; DMAddress/DMCtrl/DMDataIn driven from registered request for the whole ACCESS cycle.
REQ-026 DMWrEnable SHALL be 1 for exactly the single ACCESS cycle of a legal store, 0 at all other times.
REQ-027 Legal load: DMDataOut sampled into resp_rdata at the rising edge ending ACCESS; ACCESS -> RESP.
REQ-028 Legal store: ACCESS -> RESP with resp_rdata=0, resp_err=0.
REQ-029 Latency: legal request accepted at edge N gives resp_valid=1 from edge N+2; error request from edge N+1.
REQ-030 In RESP, resp_valid=1; resp_rdata/resp_err SHALL remain stable until resp_ready=1 at a rising edge, then RESP -> IDLE.
REQ-031 Back-to-back: minimum request spacing is 3 cycles (legal) or 2 cycles (error) with resp_ready held 1; no request accepted while in ACCESS or RESP.
REQ-032 err_count SHALL increment by 1 at entry to RESP with resp_err=1, saturating at 255.
REQ-033 DMAddress/DMCtrl/DMDataIn SHALL hold last driven values outside ACCESS.

Reset
REQ-034 rst=1 SHALL immediately force: state IDLE, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, DMWrEnable=0, DMAddress=0, DMDataIn=0, DMCtrl=000, err_count=0.
REQ-035 rst asserted during ACCESS SHALL abort the access with DMWrEnable dropping asynchronously; no response produced for the aborted request.

Verification
REQ-036 Store word addr=0x10 data=0xDEADBEEF, then load word 0x10 -> DMWrEnable high one cycle; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at N+2.
REQ-037 Load byte signed addr=0x13 (holding 0xDE) and unsigned ctrl 100 -> 0xFFFFFFDE and 0x000000DE.
REQ-038 Load half addr=0x11; word addr=0x12; store ctrl 101 -> each resp_err=1 at N+1, DMWrEnable never high, err_count=3.
REQ-039 Word load addr=MEM_BYTES-2 and addr=0xFFFFFFFE -> resp_err=1 (no wrap); word addr=MEM_BYTES-4 -> resp_err=0.
REQ-040 Hold resp_ready=0 for 5 cycles in RESP -> resp_rdata stable, req_ready=0; then resp_ready=1 -> IDLE next edge.
REQ-041 Assert rst mid-ACCESS of a store -> DMWrEnable falls without clock; memory byte unchanged; all outputs at reset values.

Source files
------------

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : single-outstanding load/store bridge to a data memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] DMAddress,
  output logic [31:0] DMDataIn,
  output logic [2:0]  DMCtrl,
  output logic        DMWrEnable,
  input  logic [31:0] DMDataOut,
  output logic [7:0]  err_count
);

  localparam logic [32:0] c_LAST_ADDR = 33'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [2:0]  w_size;
  logic [32:0] w_last_byte;
  logic        w_bad_ctrl;
  logic        w_req_err;

  // Request legality; the end address is formed in 33 bits so it cannot wrap.
  always_comb begin
    w_size = 3'd1;
    case (req_ctrl[1:0])
      2'b01:   w_size = 3'd2;
      2'b10:   w_size = 3'd4;
      default: w_size = 3'd1;
    endcase
    w_last_byte = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
    w_bad_ctrl  = (req_ctrl == 3'b011) || (req_ctrl == 3'b110) || (req_ctrl == 3'b111);
    w_req_err   = w_bad_ctrl
               || (req_we && req_ctrl[2])
               || ((req_ctrl[1:0] == 2'b01) && req_addr[0])
               || ((req_ctrl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
               || (w_last_byte > c_LAST_ADDR);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ctrl_d    = ctrl_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end else begin
            // The DM-facing registers double as the captured request.
            state_d = S_ACCESS;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            ctrl_d  = req_ctrl;
            we_d    = req_we;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        err_d   = 1'b0;
        rdata_d = we_q ? 32'd0 : DMDataOut;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      ctrl_q    <= 3'd0;
      we_q      <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ctrl_q    <= ctrl_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Write strobe decodes flop state only, so reset removes it without a clock.
  assign DMWrEnable = (state_q == S_ACCESS) && we_q;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign DMAddress  = addr_q;
  assign DMDataIn   = wdata_q;
  assign DMCtrl     = ctrl_q;
  assign err_count  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed checks of load_store_unit against a byte memory
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  localparam int MEM_BYTES = 4096;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_ctrl;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] DMAddress;
  logic [31:0] DMDataIn;
  logic [2:0]  DMCtrl;
  logic        DMWrEnable;
  logic [31:0] DMDataOut;
  logic [7:0]  err_count;

  int n_vec;
  int n_miscmp;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_ctrl   (req_ctrl),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .DMAddress  (DMAddress),
    .DMDataIn   (DMDataIn),
    .DMCtrl     (DMCtrl),
    .DMWrEnable (DMWrEnable),
    .DMDataOut  (DMDataOut),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory; writes and read data update on the falling edge.
  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [11:0] w_i0, w_i1, w_i2, w_i3;
  logic [31:0] w_rd_word;
  assign w_i0 = DMAddress[11:0];
  assign w_i1 = DMAddress[11:0] + 12'd1;
  assign w_i2 = DMAddress[11:0] + 12'd2;
  assign w_i3 = DMAddress[11:0] + 12'd3;
  assign w_rd_word = {mem[w_i3], mem[w_i2], mem[w_i1], mem[w_i0]};

  function automatic logic [31:0] ext(input logic [2:0] c, input logic [31:0] w);
    case (c)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (DMWrEnable) begin
      mem[w_i0] <= DMDataIn[7:0];
      if (DMCtrl[1:0] != 2'b00) mem[w_i1] <= DMDataIn[15:8];
      if (DMCtrl[1:0] == 2'b10) begin
        mem[w_i2] <= DMDataIn[23:16];
        mem[w_i3] <= DMDataIn[31:24];
      end
    end
    DMDataOut <= ext(DMCtrl, w_rd_word);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request with resp_ready as currently driven; returns at the falling
  // edge where resp_valid is first seen, with edges-since-acceptance in lat.
  task automatic do_req(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output int wr);
    bit done;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_ctrl  = ctrl;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_ctrl  = 3'b111;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0BAD_0BAD;
    lat  = 0;
    wr   = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (DMWrEnable) wr++;
      if (resp_valid) done = 1'b1;
    end
    if (!done) chk("resp_timeout", 32'd0, 32'd1);
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  task automatic txn(input string tag, input logic we, input logic [2:0] ctrl,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          wr;
    do_req(we, ctrl, addr, wdata, rd, e, lat, wr);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
    chk({tag, "_wr"}, 32'(wr), (we && !exp_err) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_err"},   {31'd0, resp_err}, 32'd0);
    chk({tag, "_dm_we"},      {31'd0, DMWrEnable}, 32'd0);
    chk({tag, "_dm_addr"},    DMAddress, 32'd0);
    chk({tag, "_dm_din"},     DMDataIn, 32'd0);
    chk({tag, "_dm_ctrl"},    {29'd0, DMCtrl}, 32'd0);
    chk({tag, "_err_count"},  {24'd0, err_count}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          wr;
    n_vec      = 0;
    n_miscmp   = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_ctrl   = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk_reset_outputs("rst");

    txn("st_w10",  1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn("ld_w10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("ld_b13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
    txn("ld_bu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0);
    txn("ld_h12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
    txn("ld_hu10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0);

    txn("ld_h11_mis",  1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
    txn("ld_w12_mis",  1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    txn("st_hu_ill",   1'b1, 3'b101, 32'h10, 32'h1234_5678, 32'h0, 1'b1);
    @(negedge clk);
    chk("err_count_3", {24'd0, err_count}, 32'd3);
    chk("dm_addr_hold", DMAddress, 32'h10);

    txn("ld_w_top2",   1'b0, 3'b010, MEM_BYTES - 2, 32'h0, 32'h0, 1'b1);
    txn("ld_w_fffe",   1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1);
    txn("ld_h_fffe",   1'b0, 3'b001, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1);
    txn("ld_w_end",    1'b0, 3'b010, MEM_BYTES, 32'h0, 32'h0, 1'b1);
    txn("ctrl_011",    1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    txn("ld_w_top4",   1'b0, 3'b010, MEM_BYTES - 4, 32'h0, 32'h0, 1'b0);
    txn("st_b_last",   1'b1, 3'b000, MEM_BYTES - 1, 32'h0000_00A5, 32'h0, 1'b0);
    txn("ld_bu_last",  1'b0, 3'b100, MEM_BYTES - 1, 32'h0, 32'h0000_00A5, 1'b0);
    @(negedge clk);
    chk("err_count_8", {24'd0, err_count}, 32'd8);

    // Response held off for five cycles.
    resp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat, wr);
    chk("hold_rdata0", rd, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_ready", {31'd0, req_ready}, 32'd1);
    chk("hold_release_valid", {31'd0, resp_valid}, 32'd0);

    // Reset in the middle of a store access.
    txn("st_b20", 1'b1, 3'b000, 32'h20, 32'h0000_005A, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_ctrl  = 3'b000;
    req_addr  = 32'h20;
    req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_we_before", {31'd0, DMWrEnable}, 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    txn("ld_bu20", 1'b0, 3'b100, 32'h20, 32'h0, 32'h0000_005A, 1'b0);

    // Saturation of the error counter.
    for (int i = 0; i < 260; i++) begin
      do_req(1'b0, 3'b011, 32'h0, 32'h0, rd, e, lat, wr);
    end
    @(negedge clk);
    chk("err_count_sat", {24'd0, err_count}, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

`default_nettype wire
